// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and the fill value used for lo on a divide by zero.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // lo is filled with copies of this bit when the divisor is zero
    localparam logic DBZ_LO_FILL_BIT = 1'b1;

    function automatic logic is_div_op(input logic [1:0] op_v);
        return (op_v == OP_DIV) || (op_v == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op_v);
        return (op_v == OP_MULT) || (op_v == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational two's-complement magnitude/negation helper, used to take
// operand magnitudes at accept and to restore result signs in FIX.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Negate when requested, otherwise pass the value through.
    always_comb begin
        if (negate) begin
            result = -value;
        end else begin
            result = value;
        end
    end

endmodule

// File: rtl/iter_mul_div_unit.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit: shift-add multiply and
// restoring divide at one bit per cycle, results held in HI/LO registers.
module iter_mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_t         state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [2*WIDTH-1:0] acc_r, acc_s;
    logic [WIDTH-1:0]   opnd_r, opnd_s;
    logic               is_div_r, is_div_s;
    logic               neg_res_r, neg_res_s;
    logic               neg_rem_r, neg_rem_s;
    logic               dbz_pend_r, dbz_pend_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               dbz_r, dbz_s;
    logic [WIDTH-1:0]   hi_r, hi_s;
    logic [WIDTH-1:0]   lo_r, lo_s;

    logic               accept_s;
    logic               div_zero_s;
    logic               sign1_s, sign2_s;
    logic [WIDTH-1:0]   mag1_s, mag2_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] div_next_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s, rem_fix_s;

    assign accept_s   = start && (state_r == IDLE);
    assign div_zero_s = is_div_op(op) && (input2 == {WIDTH{1'b0}});
    assign sign1_s    = is_signed_op(op) && input1[WIDTH-1];
    assign sign2_s    = is_signed_op(op) && input2[WIDTH-1];

    mdu_sign_fix #(.W(WIDTH)) u_mag1 (.value(input1), .negate(sign1_s), .result(mag1_s));
    mdu_sign_fix #(.W(WIDTH)) u_mag2 (.value(input2), .negate(sign2_s), .result(mag2_s));

    mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (.value(acc_r), .negate(neg_res_r), .result(prod_fix_s));
    mdu_sign_fix #(.W(WIDTH)) u_quot_fix (.value(acc_r[WIDTH-1:0]), .negate(neg_res_r), .result(quot_fix_s));
    mdu_sign_fix #(.W(WIDTH)) u_rem_fix (.value(acc_r[2*WIDTH-1:WIDTH]), .negate(neg_rem_r), .result(rem_fix_s));

    // acc = {partial product, remaining multiplier}: add multiplicand on LSB, shift right.
    assign mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                      + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // acc = {remainder, dividend/quotient}: shift left, trial-subtract divisor, restore on borrow.
    assign div_trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
    assign div_next_s  = div_trial_s[WIDTH]
                       ? {acc_r[2*WIDTH-2:WIDTH-1], acc_r[WIDTH-2:0], 1'b0}
                       : {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            dbz_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dbz_r      <= 1'b0;
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            acc_r      <= acc_s;
            opnd_r     <= opnd_s;
            is_div_r   <= is_div_s;
            neg_res_r  <= neg_res_s;
            neg_rem_r  <= neg_rem_s;
            dbz_pend_r <= dbz_pend_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            dbz_r      <= dbz_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
        end
    end

    // Next-state logic; a zero divisor skips CALC straight to FIX.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = div_zero_s ? FIX : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == LAST_CNT) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        cnt_s      = cnt_r;
        acc_s      = acc_r;
        opnd_s     = opnd_r;
        is_div_s   = is_div_r;
        neg_res_s  = neg_res_r;
        neg_rem_s  = neg_rem_r;
        dbz_pend_s = dbz_pend_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        dbz_s      = dbz_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    busy_s     = 1'b1;
                    dbz_s      = 1'b0;
                    cnt_s      = {CNT_W{1'b0}};
                    is_div_s   = is_div_op(op);
                    neg_res_s  = sign1_s ^ sign2_s;
                    neg_rem_s  = sign1_s;
                    dbz_pend_s = div_zero_s;
                    if (div_zero_s) begin
                        opnd_s = {WIDTH{1'b0}};
                        acc_s  = {{WIDTH{1'b0}}, input1};
                    end else if (is_div_op(op)) begin
                        opnd_s = mag2_s;
                        acc_s  = {{WIDTH{1'b0}}, mag1_s};
                    end else begin
                        opnd_s = mag1_s;
                        acc_s  = {{WIDTH{1'b0}}, mag2_s};
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            CALC: begin
                cnt_s = cnt_r + CNT_ONE;
                if (is_div_r) begin
                    acc_s = div_next_s;
                end else begin
                    acc_s = mul_next_s;
                end
            end
            FIX: begin
                busy_s = 1'b0;
                done_s = 1'b1;
                if (dbz_pend_r) begin
                    hi_s  = acc_r[WIDTH-1:0];
                    lo_s  = {WIDTH{DBZ_LO_FILL_BIT}};
                    dbz_s = 1'b1;
                end else if (is_div_r) begin
                    hi_s = rem_fix_s;
                    lo_s = quot_fix_s;
                end else begin
                    hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_s = prod_fix_s[WIDTH-1:0];
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
